// File: rtl/seq_ref_checker.sv
// seq_ref_checker: stimulus generator, golden model of an enabled flop or
// transparent latch, and an every-cycle comparator with a run verdict.
// The block is placed beside a sequential DUT in a test top.
module seq_ref_checker #(
    parameter int          WIDTH   = 1,
    parameter int          MODEL   = 0,
    parameter int          STIM    = 0,
    parameter logic [15:0] SEED    = 16'h0001,
    parameter int          LATENCY = 0,
    parameter int          WARMUP  = 2,
    parameter int          NCYCLES = 1000,
    parameter int          ERR_W   = 8,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [WIDTH-1:0] dut_q,
    output logic [WIDTH-1:0] stim,
    output logic [WIDTH-1:0] ref_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_cycle,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got
);

    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic [1:0] {
        stIdle,
        stWarmup,
        stCheck,
        stDone
    } state_t;

    state_t           state;
    state_t           nextState;
    logic             startOk;
    logic             warmLast;
    logic             lastCompare;
    logic [WCW-1:0]   warmCnt;
    logic [CNT_W-1:0] cycleIdx;
    logic [15:0]      stimReg;
    logic [15:0]      stimNext;
    logic [WIDTH-1:0] holdReg;
    logic [WIDTH-1:0] expVal;
    logic             mismatch;

    assign startOk     = start && ((state == stIdle) || (state == stDone));
    assign warmLast    = (WARMUP == 0) || (warmCnt == WCW'(WARMUP - 1));
    assign lastCompare = (cycleIdx == CNT_W'(NCYCLES - 1));
    assign stim        = stimReg[WIDTH-1:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= stIdle;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: start is only honoured when no run is in progress.
    always_comb begin
        nextState = state;
        case (state)
            stIdle, stDone: begin
                if (start) begin
                    nextState = (WARMUP == 0) ? stCheck : stWarmup;
                end
            end
            stWarmup: begin
                if (warmLast) begin
                    nextState = stCheck;
                end
            end
            stCheck: begin
                if (lastCompare) begin
                    nextState = stDone;
                end
            end
            default: nextState = stIdle;
        endcase
    end

    // State-decoded status outputs.
    always_comb begin
        busy = (state == stWarmup) || (state == stCheck);
        done = (state == stDone);
    end

    // Next stimulus value: wrapping up-counter or Galois LFSR (x^16+x^14+x^13+x^11+1).
    always_comb begin
        stimNext = stimReg + 16'd1;
        if (STIM == 1) begin
            stimNext = stimReg[0] ? ((stimReg >> 1) ^ 16'hB400) : (stimReg >> 1);
        end
    end

    // Stimulus register: reloads on start, advances only while a run is active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stimReg <= SEED;
        end else if (startOk) begin
            stimReg <= SEED;
        end else if (busy) begin
            stimReg <= stimNext;
        end
    end

    generate
        if (MODEL == 0) begin : genFlop
            // Golden enabled flop: the hold register is the model output.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    holdReg <= '0;
                end else if (startOk) begin
                    holdReg <= '0;
                end else if (en) begin
                    holdReg <= stim;
                end
            end
            assign ref_q = holdReg;
        end else begin : genLatch
            logic gate;
            assign gate  = (MODEL == 2) ? ~en : en;
            assign ref_q = gate ? stim : holdReg;
            // Golden latch: hold tracks the transparent output every cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    holdReg <= '0;
                end else if (startOk) begin
                    holdReg <= '0;
                end else begin
                    holdReg <= ref_q;
                end
            end
        end
    endgenerate

    generate
        if (LATENCY == 0) begin : genNoDelay
            assign expVal = ref_q;
        end else begin : genDelay
            logic [WIDTH-1:0] pipe [LATENCY];
            // Delay line aligning the model with a pipelined DUT.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
                end else if (startOk) begin
                    for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= ref_q;
                    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign expVal = pipe[LATENCY-1];
        end
    endgenerate

    // Mismatch defaults high so an unknown dut_q is treated as a failure.
    always_comb begin
        mismatch = 1'b1;
        if (dut_q == expVal) begin
            mismatch = 1'b0;
        end
    end

    // Run bookkeeping: warmup count, compare index, error count, first-failure capture, verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warmCnt         <= '0;
            cycleIdx        <= '0;
            err_count       <= '0;
            first_err_cycle <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
            pass            <= 1'b0;
        end else if (startOk) begin
            warmCnt         <= '0;
            cycleIdx        <= '0;
            err_count       <= '0;
            first_err_cycle <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
            pass            <= 1'b0;
        end else begin
            if (state == stWarmup) begin
                warmCnt <= warmCnt + WCW'(1);
            end
            if (state == stCheck) begin
                if (mismatch) begin
                    if (err_count != '1) begin
                        err_count <= err_count + ERR_W'(1);
                    end
                    if (err_count == '0) begin
                        first_err_cycle <= cycleIdx;
                        first_err_exp   <= expVal;
                        first_err_got   <= dut_q;
                    end
                end
                if (lastCompare) begin
                    pass <= (err_count == '0) && !mismatch;
                end else begin
                    cycleIdx <= cycleIdx + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/seq_ref_checker.md
Name: seq_ref_checker

Overview:
- Self-checking harness block for sequential-element equivalence tests: generates a data stimulus, runs a parametrised golden model of an enabled flop or transparent latch, and compares it against the DUT output every clock.
- Sits beside the imported/synthesised DUT in a test top.
- Counts mismatches and captures the first failure.
- Reports a pass/done verdict after a programmed run length.

Parameters:
- WIDTH, 1: data width of stimulus, model and DUT output; legal 1..16.
- MODEL, 0: golden model. 0 = posedge flop with enable, 1 = latch transparent while en=1, 2 = latch transparent while en=0.
- STIM, 0: stimulus source. 0 = binary up-counter, 1 = 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1), low WIDTH bits used.
- SEED, 16'h0001: reset/start value of the stimulus register; must be nonzero when STIM=1.
- LATENCY, 0: DUT pipeline delay; ref_q delayed by LATENCY cycles (0..4) before compare.
- WARMUP, 2: cycles after start with no compare.
- NCYCLES, 1000: number of compare cycles per run.
- ERR_W, 8: width of the mismatch counter.
- CNT_W, 16: width of the cycle index.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin run; honoured only in IDLE or DONE.
- en  in  1  model enable (flop enable or latch gate).
- dut_q  in  WIDTH  DUT output under test.
- stim  out  WIDTH  stimulus to DUT data input.
- ref_q  out  WIDTH  golden model output (undelayed).
- busy  out  1  high in WARMUP and CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid in DONE: err_count==0.
- err_count  out  ERR_W  mismatches this run, saturating.
- first_err_cycle  out  CNT_W  compare index (0-based) of first mismatch.
- first_err_exp  out  WIDTH  expected value at first mismatch.
- first_err_got  out  WIDTH  dut_q at first mismatch.

Behaviour:
- Reset (async, any state):
  - state=IDLE, stim=SEED[WIDTH-1:0], model hold reg=0, delay pipe=0.
  - All counters and capture registers=0, busy=done=pass=0.
- FSM: IDLE -start-> WARMUP (or CHECK if WARMUP=0); WARMUP after WARMUP cycles -> CHECK; CHECK after NCYCLES compares -> DONE; DONE -start-> WARMUP/CHECK. start ignored while busy.
- On accepted start: err_count, first_err_*, cycle index, delay pipe cleared; stim reloaded to SEED; model hold cleared.
- Stimulus advances once per clk while busy (counter +1 wrapping at 2^WIDTH; LFSR one shift). Frozen in IDLE/DONE.
- Model:
  - MODEL 0: ref_q register loads stim at posedge when en=1, else holds.
  - MODEL 1: ref_q = en ? stim : hold (combinational); hold <= ref_q each posedge.
  - MODEL 2: same with en inverted.
- Compare: in CHECK at each posedge, exp = ref_q delayed LATENCY cycles (LATENCY=0: current ref_q).
  - mismatch = (dut_q != exp); X on dut_q counts as mismatch.
- Mismatch handling:
  - err_count increments, saturating at 2^ERR_W-1 (no wrap).
  - The first mismatch of the run loads first_err_cycle/exp/got; later mismatches do not overwrite them.
- Cycle index counts 0..NCYCLES-1 in CHECK; the transition to DONE occurs on the posedge of compare NCYCLES-1, and that compare is counted.
- pass registered on entry to DONE; done/pass held until next accepted start or reset.
- Reset asserted mid-run aborts immediately; no verdict is produced.

Test Plan:
- MODEL=0, STIM=0, WIDTH=1, en toggling every cycle, dut_q driven from an ideal enabled flop, NCYCLES=1000 -> done after 2+1000 cycles, pass=1, err_count=0.
- MODEL=1, STIM=0, en held 1 with dut_q=stim -> pass=1; then en=0 for 5 cycles with dut_q tied 0 while hold=1 -> err_count=5, first_err_exp=1, first_err_got=0.
- WIDTH=8, STIM=1, SEED=16'hACE1, LATENCY=2, DUT = 2-stage pipe of an enabled flop -> pass=1; same run with LATENCY=1 -> pass=0, first_err_cycle=0 (first compare whose exp differs).
- ERR_W=4, dut_q inverted of model for 100 compares -> err_count=15 (saturated), first_err_cycle=0, pass=0.
- start pulsed in CHECK -> ignored, run length unchanged; start in DONE -> counters cleared and stim reloaded to SEED on the next cycle.
- rst asserted mid-CHECK at compare 500 -> outputs zero asynchronously, state IDLE; subsequent start yields a full fresh run.
